otter_io_hub: RTL and testbench

Parametrised memory-mapped I/O hub for the OTTER MCU IOBUS, replacing the ad-hoc per-board port decode at the top level. It provides N_OUT readable/writable output registers, synchronised switch inputs, debounced buttons with rising-edge capture into a pending register, and a maskable, registered interrupt request for the MCU INTR pin. The hub sits between RISCV_OTTER (IOBUS_*) and board pins or display drivers.

---
 rtl/otter_io_pkg.sv | 14 +
 rtl/otter_debounce.sv | 31 +++
 rtl/otter_io_hub.sv | 75 +++++++
 tb/tb_otter_io_hub.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// otter_io_pkg: address map constants and decode helper for the OTTER I/O hub.
package otter_io_pkg;
    localparam logic [31:0] BASE_IN_DEF  = 32'h11008000;
    localparam logic [31:0] BASE_OUT_DEF = 32'h1100C000;
    localparam logic [31:0] OFS_SW   = 32'h0;
    localparam logic [31:0] OFS_BTN  = 32'h4;
    localparam logic [31:0] OFS_PEND = 32'h8;
    localparam logic [31:0] OFS_MASK = 32'hC;
    localparam int OUT_STRIDE = 4;

    function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base, input logic [31:0] ofs);
        return addr == base + ofs;
    endfunction
endpackage

// File: rtl/otter_debounce.sv
// otter_debounce: 2-flop synchroniser plus counter debouncer with a pulse on each 0->1 change of db.
module otter_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
    logic meta, sync_q, expire;
    logic [CW-1:0] cnt;
    assign expire = (sync_q != db) && (cnt == LAST);
    assign rise = expire && !db;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            cnt    <= '0;
            db     <= 1'b0;
        end else begin
            meta   <= raw;
            sync_q <= meta;
            cnt    <= (sync_q == db || expire) ? '0 : cnt + 1'b1;
            if (expire)
                db <= ~db;
        end
    end
endmodule

// File: rtl/otter_io_hub.sv
// otter_io_hub: IOBUS-mapped output registers, synchronised switches, debounced buttons
// with W1C pending capture and a registered, maskable interrupt request.
module otter_io_hub
    import otter_io_pkg::*;
#(
    parameter int          N_OUT     = 4,
    parameter int          OUT_W     = 16,
    parameter int          N_BTN     = 5,
    parameter int          SW_W      = 16,
    parameter int          DB_CYCLES = 16,
    parameter logic [31:0] BASE_IN   = BASE_IN_DEF,
    parameter logic [31:0] BASE_OUT  = BASE_OUT_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [31:0]            IOBUS_ADDR,
    input  logic [31:0]            IOBUS_OUT,
    input  logic                   IOBUS_WR,
    output logic [31:0]            IOBUS_IN,
    input  logic [SW_W-1:0]        switches,
    input  logic [N_BTN-1:0]       buttons,
    output logic [N_OUT*OUT_W-1:0] out_regs,
    output logic                   intr
);
    logic [SW_W-1:0] sw_meta, sw_sync;
    logic [N_BTN-1:0] db, rise, pending, mask, pending_next, mask_next, clr;
    logic [N_OUT-1:0][OUT_W-1:0] out_q;
    logic unused_bits;
    assign unused_bits = ^IOBUS_OUT;
    assign out_regs = out_q;

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        otter_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk(CLK), .rst(RST), .raw(buttons[b]), .db(db[b]), .rise(rise[b])
        );
    end

    // A rise in the same cycle as a W1C of that bit wins.
    always_comb begin
        clr = (IOBUS_WR && addr_hit(IOBUS_ADDR, BASE_IN, OFS_PEND)) ? IOBUS_OUT[N_BTN-1:0] : '0;
        mask_next = (IOBUS_WR && addr_hit(IOBUS_ADDR, BASE_IN, OFS_MASK)) ? IOBUS_OUT[N_BTN-1:0] : mask;
        pending_next = (pending & ~clr) | rise;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sw_meta <= '0;
            sw_sync <= '0;
            pending <= '0;
            mask    <= '0;
            intr    <= 1'b0;
            out_q   <= '0;
        end else begin
            sw_meta <= switches;
            sw_sync <= sw_meta;
            pending <= pending_next;
            mask    <= mask_next;
            intr    <= |(pending_next & mask_next);
            for (int i = 0; i < N_OUT; i++)
                if (IOBUS_WR && addr_hit(IOBUS_ADDR, BASE_OUT, OUT_STRIDE * i))
                    out_q[i] <= IOBUS_OUT[OUT_W-1:0];
        end
    end

    always_comb begin
        IOBUS_IN = '0;
        if (addr_hit(IOBUS_ADDR, BASE_IN, OFS_SW))   IOBUS_IN = 32'(sw_sync);
        if (addr_hit(IOBUS_ADDR, BASE_IN, OFS_BTN))  IOBUS_IN = 32'(db);
        if (addr_hit(IOBUS_ADDR, BASE_IN, OFS_PEND)) IOBUS_IN = 32'(pending);
        if (addr_hit(IOBUS_ADDR, BASE_IN, OFS_MASK)) IOBUS_IN = 32'(mask);
        for (int i = 0; i < N_OUT; i++)
            if (addr_hit(IOBUS_ADDR, BASE_OUT, OUT_STRIDE * i))
                IOBUS_IN = 32'(out_q[i]);
    end
endmodule

// File: tb/tb_otter_io_hub.sv
// tb_otter_io_hub: randomized scoreboard bench for otter_io_hub against a cycle-level behavioural model.
module tb_otter_io_hub;
    localparam int N_OUT = 4, OUT_W = 16, N_BTN = 5, SW_W = 16, DB = 16;
    localparam logic [31:0] BI = 32'h11008000, BO = 32'h1100C000;

    logic CLK = 0, RST = 1, IOBUS_WR = 0;
    logic [31:0] IOBUS_ADDR = 0, IOBUS_OUT = 0, IOBUS_IN;
    logic [SW_W-1:0] switches = 0;
    logic [N_BTN-1:0] buttons = 0;
    logic [N_OUT*OUT_W-1:0] out_regs;
    logic intr;

    always #5 CLK = ~CLK;

    otter_io_hub #(.N_OUT(N_OUT), .OUT_W(OUT_W), .N_BTN(N_BTN), .SW_W(SW_W), .DB_CYCLES(DB)) dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT), .IOBUS_WR(IOBUS_WR),
        .IOBUS_IN(IOBUS_IN), .switches(switches), .buttons(buttons), .out_regs(out_regs), .intr(intr)
    );

    // Behavioural model: inputs seen two edges late, db flips after DB consecutive differing edges.
    logic [SW_W-1:0] m_sw1, m_sw2;
    logic [N_BTN-1:0] m_b1, m_b2, m_db, m_pend, m_mask, m_rise;
    logic [OUT_W-1:0] m_out [N_OUT];
    int m_run [N_BTN];
    logic m_intr;

    always @(posedge CLK) begin
        if (RST) begin
            m_sw1 = 0; m_sw2 = 0; m_b1 = 0; m_b2 = 0; m_db = 0; m_pend = 0; m_mask = 0; m_intr = 0;
            for (int i = 0; i < N_OUT; i++) m_out[i] = 0;
            for (int b = 0; b < N_BTN; b++) m_run[b] = 0;
        end else begin
            m_rise = 0;
            for (int b = 0; b < N_BTN; b++) begin
                if (m_b2[b] != m_db[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_db[b] = ~m_db[b];
                        m_run[b] = 0;
                        m_rise[b] = m_db[b];
                    end
                end else m_run[b] = 0;
            end
            m_b2 = m_b1; m_b1 = buttons; m_sw2 = m_sw1; m_sw1 = switches;
            if (IOBUS_WR) begin
                if (IOBUS_ADDR == BI + 8) m_pend = m_pend & ~IOBUS_OUT[N_BTN-1:0];
                if (IOBUS_ADDR == BI + 12) m_mask = IOBUS_OUT[N_BTN-1:0];
                for (int i = 0; i < N_OUT; i++)
                    if (IOBUS_ADDR == BO + 32'(4 * i)) m_out[i] = IOBUS_OUT[OUT_W-1:0];
            end
            m_pend = m_pend | m_rise;
            m_intr = |(m_pend & m_mask);
        end
    end

    function automatic logic [31:0] model_read(input logic [31:0] a);
        model_read = 0;
        if (a == BI) model_read = 32'(m_sw2);
        if (a == BI + 4) model_read = 32'(m_db);
        if (a == BI + 8) model_read = 32'(m_pend);
        if (a == BI + 12) model_read = 32'(m_mask);
        for (int i = 0; i < N_OUT; i++)
            if (a == BO + 32'(4 * i)) model_read = 32'(m_out[i]);
    endfunction

    function automatic logic [63:0] model_outs();
        model_outs = 0;
        for (int i = 0; i < N_OUT; i++) model_outs[i*OUT_W +: OUT_W] = m_out[i];
    endfunction

    // Scoreboard: kind 0 = IOBUS_IN, 1 = intr, 2 = out_regs
    typedef struct { int kind; logic [63:0] exp; string name; } exp_t;
    exp_t sbq[$];
    exp_t cur;
    logic [63:0] act;
    event smp;
    int n_cmp = 0, n_bad = 0;

    always begin
        @(smp);
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            act = cur.kind == 0 ? 64'(IOBUS_IN) : cur.kind == 1 ? 64'(intr) : 64'(out_regs);
            n_cmp++;
            if (act !== cur.exp) begin
                n_bad++;
                $display("FAIL %s: got %0h expected %0h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic chk_rd(input logic [31:0] a, input logic [31:0] e, input string n);
        IOBUS_ADDR = a; #1;
        sbq.push_back('{0, 64'(e), n}); -> smp; #1;
    endtask
    task automatic chk_intr(input logic e, input string n);
        #1 sbq.push_back('{1, 64'(e), n}); -> smp; #1;
    endtask
    task automatic chk_out(input logic [63:0] e, input string n);
        #1 sbq.push_back('{2, e, n}); -> smp; #1;
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge CLK);
        IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1;
        @(negedge CLK);
        IOBUS_WR = 0;
    endtask

    initial begin
        logic found;
        logic [31:0] a;
        switches = 16'hFFFF;
        cyc(1);
        chk_out(0, "rst_out");
        chk_intr(0, "rst_intr");
        cyc(1);
        RST = 0;
        chk_rd(BI + 8, 0, "rst_pend");
        chk_rd(BI + 12, 0, "rst_mask");
        cyc(1);
        chk_rd(BI, 0, "sw_sync_1");
        cyc(1);
        chk_rd(BI, 32'h0000FFFF, "sw_sync_2");

        wr(BO + 4, 32'h1234ABCD);
        chk_out(64'h00000000ABCD0000, "out1_val");
        chk_rd(BO + 4, 32'h0000ABCD, "out1_rd");
        wr(BO + 4 * N_OUT, 32'hDEADBEEF);
        chk_out(64'h00000000ABCD0000, "out_oob_val");
        chk_rd(BO + 4 * N_OUT, 0, "out_oob_rd");
        for (int t = 0; t < 16; t++) begin
            a = BO + 32'(4 * $urandom_range(0, N_OUT));
            wr(a, $urandom);
            chk_out(model_outs(), "out_rand_val");
            a = BO + 32'(4 * $urandom_range(0, N_OUT));
            chk_rd(a, model_read(a), "out_rand_rd");
        end

        buttons[0] = 1;
        cyc(10);
        buttons[0] = 0;
        cyc(25);
        chk_rd(BI + 4, 0, "glitch_db");
        chk_rd(BI + 8, 0, "glitch_pend");
        buttons[0] = 1;
        cyc(DB + 1);
        chk_rd(BI + 4, 0, "db_early");
        cyc(1);
        chk_rd(BI + 4, 1, "db_rise");
        chk_rd(BI + 8, 1, "pend_rise");
        cyc(22);
        chk_rd(BI + 4, model_read(BI + 4), "db_hold");

        buttons[0] = 0;
        cyc(20);
        wr(BI + 8, 32'h1F);
        wr(BI + 12, 32'h1);
        chk_intr(0, "intr_idle");
        buttons[0] = 1;
        cyc(DB + 1);
        chk_intr(0, "intr_early");
        cyc(1);
        chk_intr(1, "intr_rise");
        chk_rd(BI + 8, 1, "intr_pend");
        wr(BI + 8, 32'h1);
        chk_intr(0, "intr_w1c");
        chk_rd(BI + 8, 0, "pend_w1c");

        buttons[0] = 0;
        cyc(20);
        wr(BI + 12, 32'h4);
        buttons[2] = 1;
        found = 0;
        for (int t = 0; t < 40 && !found; t++) begin
            @(negedge CLK);
            if (m_b2[2] != m_db[2] && m_run[2] == DB - 1 && !m_db[2]) begin
                found = 1;
                IOBUS_ADDR = BI + 8; IOBUS_OUT = 32'h4; IOBUS_WR = 1;
                @(negedge CLK);
                IOBUS_WR = 0;
            end
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL collision_wait: got no rise expected rise within 40 cycles");
        end
        chk_rd(BI + 8, 32'h4, "collision_pend");
        chk_intr(1, "collision_intr");

        wr(BI + 12, 32'h0);
        chk_intr(0, "mask_off_intr");
        chk_rd(BI + 8, 32'h4, "mask_off_pend");
        wr(BI + 12, 32'h4);
        chk_intr(1, "mask_late_intr");

        buttons[1] = 1;
        cyc(10);
        RST = 1;
        buttons[1] = 0;
        cyc(1);
        RST = 0;
        chk_rd(BI + 8, 0, "midrst_pend0");
        cyc(25);
        chk_rd(BI + 8, model_read(BI + 8), "midrst_pend");
        chk_rd(BI + 4, model_read(BI + 4), "midrst_db");
        chk_intr(m_intr, "midrst_intr");

        wr(BI + 12, $urandom);
        for (int t = 0; t < 400; t++) begin
            @(negedge CLK);
            IOBUS_WR = 0;
            if ($urandom_range(0, 11) == 0) buttons[$urandom_range(0, N_BTN - 1)] ^= 1'b1;
            if ($urandom_range(0, 19) == 0) switches = SW_W'($urandom);
            a = BI + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                IOBUS_OUT = $urandom;
                IOBUS_WR = 1;
            end
            chk_rd(a, model_read(a), "rand_rd");
            chk_intr(m_intr, "rand_intr");
        end
        @(negedge CLK);
        IOBUS_WR = 0;
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
